// File: rtl/mvm_pkg.sv
// Shared types and sizing for the matrix-vector sequencer.
// RES_MULT is the result width multiplier relative to DATA_WIDTH.
package mvm_pkg;
    localparam int DIM_DEF        = 8;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int RES_MULT       = 3;
    localparam int RES_WIDTH      = RES_MULT * DATA_WIDTH_DEF;
    localparam int IDX_W          = $clog2(DIM_DEF);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        UNLOAD,
        CLEAR
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mvm_sequencer_if.sv
// Host stream, datapath FIFO strobes and result stream of the sequencer.
// master = sequencer side, slave = host/datapath side.
interface mvm_sequencer_if
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIM        = DIM_DEF
) ();
    logic                           start;
    logic                           in_valid;
    logic [DATA_WIDTH-1:0]          in_data;
    logic                           in_ready;
    logic                           a_wren;
    logic [DATA_WIDTH-1:0]          a_fifo_in [DIM];
    logic                           b_wren;
    logic [DATA_WIDTH-1:0]          b_fifo_in;
    logic                           Clr;
    logic                           mvm_done;
    logic [RES_MULT*DATA_WIDTH-1:0] mvm_out [DIM];
    logic                           res_valid;
    logic [RES_MULT*DATA_WIDTH-1:0] res_data;
    logic                           res_ready;
    logic                           busy;
    logic                           err;

    modport master (
        input  start, in_valid, in_data, mvm_done, mvm_out, res_ready,
        output in_ready, a_wren, a_fifo_in, b_wren, b_fifo_in, Clr,
               res_valid, res_data, busy, err
    );

    modport slave (
        output start, in_valid, in_data, mvm_done, mvm_out, res_ready,
        input  in_ready, a_wren, a_fifo_in, b_wren, b_fifo_in, Clr,
               res_valid, res_data, busy, err
    );
endinterface

// File: rtl/mvm_idx_cnt.sv
// Mod-DIM index counter: synchronous clear wins over enable, wraps after DIM-1.
// last_o flags the final index combinationally from the registered count.
module mvm_idx_cnt
    import mvm_pkg::*;
#(
    parameter  int DIM = DIM_DEF,
    localparam int W   = idx_width(DIM)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == W'(DIM - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mvm_sequencer.sv
// Sequences one job on mat_vec_mult: pack A by columns, write B, wait done, stream results, pulse Clr.
// Latency: A column / B byte strobe 1 cycle after accept; results 1 cycle after done; host stalls via in_valid/res_ready.
// MVM_SEQ_TIMEOUT_EN adds a WAIT watchdog that sets a sticky err and aborts to CLEAR.
module mvm_sequencer
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int DIM            = DIM_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    mvm_sequencer_if.master bus
);
    localparam int IW = idx_width(DIM);
    localparam int RW = RES_MULT * DATA_WIDTH;

    if (DIM < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mvm_sequencer: DIM must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_e                state_q, state_d;
    logic                  accept, cnt_clr, timeout;
    logic                  byte_en, byte_last, col_en, col_last, res_en, res_last;
    logic [IW-1:0]         byte_idx, col_idx_unused, res_idx;
    logic [DATA_WIDTH-1:0] stage_q  [DIM];
    logic [DATA_WIDTH-1:0] a_fifo_q [DIM];
    logic [DATA_WIDTH-1:0] b_fifo_q;
    logic                  a_wren_q, b_wren_q;
    logic [RW-1:0]         result_q [DIM];

    assign bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign accept        = bus.in_valid && bus.in_ready;
    assign cnt_clr       = (state_q == IDLE);
    assign byte_en       = accept && (state_q == LOAD_A);
    // The column counter doubles as the B byte counter once A is complete.
    assign col_en        = (byte_en && byte_last) || (accept && (state_q == LOAD_B));
    assign res_en        = (state_q == UNLOAD) && bus.res_ready;

    assign bus.a_wren    = a_wren_q;
    assign bus.a_fifo_in = a_fifo_q;
    assign bus.b_wren    = b_wren_q;
    assign bus.b_fifo_in = b_fifo_q;
    assign bus.Clr       = (state_q == CLEAR);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == UNLOAD);
    assign bus.res_data  = (state_q == UNLOAD) ? result_q[res_idx] : '0;

    mvm_idx_cnt #(.DIM(DIM)) u_byte_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(byte_en),
        .cnt_o(byte_idx), .last_o(byte_last)
    );

    mvm_idx_cnt #(.DIM(DIM)) u_col_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(col_en),
        .cnt_o(col_idx_unused), .last_o(col_last)
    );

    mvm_idx_cnt #(.DIM(DIM)) u_res_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(res_en),
        .cnt_o(res_idx), .last_o(res_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = LOAD_A;
            LOAD_A:  if (byte_en && byte_last && col_last) state_d = LOAD_B;
            LOAD_B:  if (accept && col_last) state_d = WAIT;
            WAIT: begin
                if (bus.mvm_done)  state_d = UNLOAD;
                else if (timeout)  state_d = CLEAR;
            end
            UNLOAD:  if (res_en && res_last) state_d = CLEAR;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q  <= '{default: '0};
            a_fifo_q <= '{default: '0};
            b_fifo_q <= '0;
            a_wren_q <= 1'b0;
            b_wren_q <= 1'b0;
            result_q <= '{default: '0};
        end else begin
            a_wren_q <= 1'b0;
            b_wren_q <= 1'b0;
            if (byte_en) begin
                stage_q[byte_idx] <= bus.in_data;
                // The closing byte bypasses the stage so the column leaves one cycle later.
                if (byte_last) begin
                    for (int r = 0; r < DIM - 1; r++) begin
                        a_fifo_q[r] <= stage_q[r];
                    end
                    a_fifo_q[DIM-1] <= bus.in_data;
                    a_wren_q        <= 1'b1;
                end
            end
            if (accept && (state_q == LOAD_B)) begin
                b_fifo_q <= bus.in_data;
                b_wren_q <= 1'b1;
            end
            if ((state_q == WAIT) && bus.mvm_done) begin
                result_q <= bus.mvm_out;
            end
        end
    end

`ifdef MVM_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q;
    logic          err_q;

    assign timeout = (state_q == WAIT) && !bus.mvm_done && (wd_q == WW'(TIMEOUT_CYCLES - 1));
    assign bus.err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= (state_q == WAIT) ? wd_q + 1'b1 : '0;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_mvm_sequencer.sv
// Randomized bench for mvm_sequencer against a job-level reference model of the host protocol.
module tb_mvm_sequencer;
    import mvm_pkg::*;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int RW = 3 * DW;
    localparam int TO = 16;
    localparam int NB = N * N + N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mvm_sequencer_if #(.DATA_WIDTH(DW), .DIM(N)) bus ();

    mvm_sequencer #(.DATA_WIDTH(DW), .DIM(N), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Job contents as the host sees them: mat[row][col] and vec[i].
    logic [DW-1:0] mat [N][N];
    logic [DW-1:0] vec [N];

    // Reference model: job phase plus what the datapath-facing outputs must show next cycle.
    typedef enum int {M_IDLE, M_LOAD, M_WAIT, M_UNLOAD, M_CLEAR} mphase_e;
    mphase_e       m_ph = M_IDLE;
    int            acc_n = 0, res_ptr = 0, wd = 0;
    bit            pend_a = 0, pend_b = 0, post_rst = 1, err_exp = 0;
    logic [DW-1:0] pend_b_val = '0;
    logic [DW-1:0] exp_af [N] = '{default: '0};
    logic [RW-1:0] exp_res [N];
    logic [63:0]   af_got, af_exp;

    always @(negedge clk) begin
        for (int r = 0; r < N; r++) begin
            af_got[r*DW +: DW] = bus.a_fifo_in[r];
            af_exp[r*DW +: DW] = exp_af[r];
        end
        check_eq("in_ready", bus.in_ready, m_ph == M_LOAD);
        check_eq("busy", bus.busy, m_ph != M_IDLE);
        check_eq("a_wren", bus.a_wren, pend_a);
        check_eq("a_fifo_in", af_got, af_exp);
        check_eq("b_wren", bus.b_wren, pend_b);
        if (pend_b || post_rst) check_eq("b_fifo_in", bus.b_fifo_in, post_rst ? '0 : pend_b_val);
        check_eq("res_valid", bus.res_valid, m_ph == M_UNLOAD);
        if (m_ph == M_UNLOAD) check_eq("res_data", bus.res_data, exp_res[res_ptr]);
        if (post_rst) check_eq("res_data_rst", bus.res_data, 0);
        check_eq("Clr", bus.Clr, m_ph == M_CLEAR);
        check_eq("err", bus.err, err_exp);

        post_rst = 0;
        pend_a   = 0;
        pend_b   = 0;
        if (!rst_n) begin
            m_ph     = M_IDLE;
            post_rst = 1;
            err_exp  = 0;
            for (int r = 0; r < N; r++) exp_af[r] = '0;
        end else begin
            case (m_ph)
                M_IDLE: if (bus.start) begin
                    m_ph  = M_LOAD;
                    acc_n = 0;
                end
                M_LOAD: if (bus.in_valid) begin
                    if (acc_n < N * N) begin
                        if (acc_n % N == N - 1) begin
                            pend_a = 1;
                            for (int r = 0; r < N; r++) exp_af[r] = mat[r][acc_n / N];
                        end
                    end else begin
                        pend_b     = 1;
                        pend_b_val = vec[acc_n - N * N];
                    end
                    acc_n++;
                    if (acc_n == NB) begin
                        m_ph = M_WAIT;
                        wd   = 0;
                    end
                end
                M_WAIT: begin
                    if (bus.mvm_done) begin
                        for (int r = 0; r < N; r++) exp_res[r] = bus.mvm_out[r];
                        res_ptr = 0;
                        m_ph    = M_UNLOAD;
                    end
`ifdef MVM_SEQ_TIMEOUT_EN
                    else if (wd == TO - 1) begin
                        err_exp = 1;
                        m_ph    = M_CLEAR;
                    end else begin
                        wd++;
                    end
`endif
                end
                M_UNLOAD: if (bus.res_ready) begin
                    res_ptr++;
                    if (res_ptr == N) m_ph = M_CLEAR;
                end
                M_CLEAR: m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int r = 0; r < N; r++) begin
            vec[r] = DW'($urandom);
            for (int c = 0; c < N; c++) mat[r][c] = DW'($urandom);
            bus.mvm_out[r] = RW'($urandom);
        end
    endtask

    // gap: 0 = back-to-back, 1 = every other cycle, 2 = random. Stops after stop_at accepted bytes.
    task automatic load_job(input int gap, input bit spurious, input int stop_at);
        int idx = 0;
        int cyc = 0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (idx < stop_at && cyc < 2000) begin
            case (gap)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (cyc % 2 == 0);
                default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            bus.in_data = (idx < N * N) ? mat[idx % N][idx / N] : vec[idx - N * N];
            if (spurious) begin
                bus.mvm_done = (idx == 20);
                bus.start    = (idx == N * N + 4);
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.mvm_done = 1'b0;
        bus.start    = 1'b0;
        if (idx != stop_at) check_eq("load_budget", idx, stop_at);
    endtask

    // stall >= 0 holds res_ready low for that many valid cycles per result; < 0 is random.
    task automatic finish_job(input int wait_cyc, input int stall, input bit fire_done);
        int  cyc = 0;
        int  held = 0;
        bit  seen_clr = 0;
        repeat (wait_cyc) tick();
        if (fire_done) begin
            bus.mvm_done = 1'b1;
            tick();
            bus.mvm_done = 1'b0;
        end
        while (!seen_clr && cyc < 400) begin
            bus.res_ready = (stall >= 0) ? (held >= stall) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.res_valid && bus.res_ready) held = 0;
            else if (bus.res_valid) held++;
            if (bus.Clr) seen_clr = 1;
            tick();
            cyc++;
        end
        bus.res_ready = 1'b0;
        if (!seen_clr) check_eq("clr_budget", 0, 1);
        tick();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mvm_done  = 1'b0;
        bus.res_ready = 1'b0;
        for (int r = 0; r < N; r++) bus.mvm_out[r] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Nominal: column k carries k+1, vector all 2, results 100*r with 3-cycle stalls.
        for (int r = 0; r < N; r++) begin
            vec[r] = DW'(2);
            for (int c = 0; c < N; c++) mat[r][c] = DW'(c + 1);
        end
        load_job(0, 0, NB);
        for (int r = 0; r < N; r++) bus.mvm_out[r] = RW'(100 * r);
        finish_job(20, 3, 1);

        fill_random();
        load_job(1, 0, NB);
        finish_job(5, -1, 1);

        fill_random();
        load_job(2, 1, NB);
        finish_job(3, -1, 1);

        // Reset after three B bytes, then a fresh job must start from column 0.
        fill_random();
        load_job(0, 0, N * N + 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        fill_random();
        load_job(2, 0, NB);
        finish_job(0, -1, 1);

`ifdef MVM_SEQ_TIMEOUT_EN
        fill_random();
        load_job(0, 0, NB);
        finish_job(0, 0, 0);
        fill_random();
        load_job(2, 0, NB);
        finish_job(2, -1, 1);
`endif

        for (int j = 0; j < 3; j++) begin
            fill_random();
            load_job(2, 0, NB);
            finish_job($urandom_range(0, 10), -1, 1);
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
